onehot_decoder_scan: RTL and testbench
======================================

# onehot_decoder_scan

4-to-16 decoder with multiplexed decimal display, the inverse of the lab's 16-to-4 priority encoder. Takes a 4-bit code from switches and, while enabled by a button, drives a one-hot pattern onto 16 LEDs. Shows the code's decimal index (0–15) on two time-multiplexed seven-segment digits. Sits on the board I/O: synchronizes switch and button inputs, scans the display, and drives all outputs from registers.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each display digit stays lit before the scan advances; legal range ≥2.
- `DEB_CNT`, default 1000000: consecutive stable cycles the button must hold before its debounced state changes. Only used when `BTN_DEBOUNCE_EN` is defined.
- `clk` in 1: single system clock; all flops on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btnD` in 1: enable button, active-high, asynchronous to `clk`.
- `sw` in 4: binary code, 0–15, asynchronous to `clk`.
- `led` out 16: one-hot decode; `led[sw]`=1 when enabled, otherwise all 0.
- `sel_seg` out 8: digit select, active-low; only bits 0 and 1 are ever driven low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low (0 = lit).

## Operation
- **Input synchronization:** `sw` and `btnD` each pass through a 2-flop synchronizer, giving `sw_s` and `btn_s`.
- **Enable:** `en` = `btn_s` (or the debounced version, see Configuration).
- **LED output:** `led` is a register loaded every cycle with `en ? (16'h0001 << sw_s) : 16'h0000`.
- **Scan counter:** `scan_cnt` counts 0..`SCAN_DIV`-1 and wraps.
  - On wrap, `digit` toggles (0 → 1 → 0).
  - The counter runs regardless of `en`.
- **Display, enabled:**
  - `digit`=0 (units): `sel_seg`=8'b11111110; `seg` = pattern of (`sw_s` mod 10).
  - `digit`=1 (tens): `sel_seg`=8'b11111101; `seg` = pattern '1' when `sw_s` ≥ 10.
  - Leading-zero suppression: when `sw_s` < 10, the tens digit shows `seg`=7'b1111111 (blank) while `sel_seg` still selects digit 1.
- **Display, disabled:** `sel_seg`=8'hFF and `seg`=7'b1111111 every cycle.
- **Segment patterns (gfedcba):**
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- **Mid-operation changes:** a change of `sw` while enabled is reflected on both `led` and the current digit with no glitch to other LEDs. `led` never has more than one bit set.
- **Reset:** asserting `rst` at any time immediately forces the reset state below, including mid-scan and mid-debounce.

## Timing
- **Reset values:**
  - `led`=16'h0000, `sel_seg`=8'hFF, `seg`=7'b1111111.
  - `scan_cnt`=0, `digit`=0.
  - All synchronizer and debounce flops = 0, so `en`=0.
- **Data latency:** a change on `sw` sampled at edge k appears on `led`/`seg` after edge k+2 (two sync stages plus one output register).
- **Enable latency:**
  - Without debounce: a `btnD` change sampled at edge k affects outputs after edge k+2.
  - With debounce: outputs change after edge k+1+`DEB_CNT`+1.
- **Scan timing:**
  - After reset, `digit`=0 for exactly `SCAN_DIV` cycles, then 1 for `SCAN_DIV` cycles, repeating.
  - The digit switch shows on `sel_seg` one cycle after the wrap, because the output is registered.
- **Simultaneous events:** when `en` falls in the same cycle as a digit toggle, the blank output wins.

## Configuration
- Macro: `BTN_DEBOUNCE_EN`.
- **Defined:**
  - A debounce counter compares `btn_s` against the debounced state `btn_d`.
  - The counter increments while they differ and clears when they are equal.
  - On reaching `DEB_CNT`-1, `btn_d` takes `btn_s` and the counter clears.
  - `en` = `btn_d`.
  - A pulse shorter than `DEB_CNT` cycles never changes `en`.
- **Not defined:** no debounce counter is instantiated; `en` = `btn_s`, and `DEB_CNT` is ignored.

## Test plan
All tests use `SCAN_DIV`=4 and `DEB_CNT`=8.
- **Reset:** assert `rst` mid-run with `btnD`=1, `sw`=5 → on the same cycle `led`=0, `sel_seg`=FF, `seg`=7F; after release, outputs recover 3 edges after `en` re-synchronizes.
- **Decode sweep:** `btnD`=1, `sw` swept 0..15 → `led` = `1<<sw` after 3 edges; units digit shows sw mod 10; tens digit shows '1' (1111001) for 10–15 and blank for 0–9.
- **Scan:** `btnD`=1, `sw`=12 → `sel_seg` alternates FE/FD every 4 cycles; `seg`=0100100 on FE and 1111001 on FD.
- **Disable:** drop `btnD` with `sw`=3 → `led`=0, `sel_seg`=FF and `seg`=7F after 3 edges; `scan_cnt` keeps running.
- **Debounce (macro defined):** `btnD` pulse of 5 cycles → `en` never rises and `led` stays 0; a hold of ≥8 cycles → `led` = `1<<sw` 11 edges after the first sample.
- **No debounce (macro undefined):** `btnD` pulse of 1 cycle → exactly one cycle of nonzero `led`.

Source files
------------

// File: rtl/onehot_decoder_scan.sv
// onehot_decoder_scan
//   4-to-16 one-hot decoder for the board I/O. While the (synchronized)
//   enable button is held, led[sw] is lit and the decimal value of sw
//   (0..15) is shown on two time-multiplexed seven-segment digits, with
//   the tens digit blanked for values below 10. All outputs are registered.
//
//   Optional feature macro: BTN_DEBOUNCE_EN
//     defined   -> btnD is debounced over DEB_CNT stable cycles before use
//     undefined -> the synchronized btnD is used directly, DEB_CNT unused
//
// Parameters
//   SCAN_DIV  cycles each digit stays lit (>= 2)
//   DEB_CNT   stable cycles required to change the debounced button state
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   btnD     enable button, active-high, asynchronous
//   sw[3:0]  binary code, asynchronous
//   led      one-hot decode of sw when enabled, else 0
//   sel_seg  digit select, active-low (FE units, FD tens, FF off)
//   seg      segments {g,f,e,d,c,b,a}, active-low
module onehot_decoder_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnD,
  input  logic [3:0]  sw,
  output logic [15:0] led,
  output logic [7:0]  sel_seg,
  output logic [6:0]  seg
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } digit_e;

  logic [3:0]        sw_meta_q, sw_s_q;
  logic              btn_meta_q, btn_s_q;
  logic              en;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  digit_e            digit_q, digit_d;
  logic [15:0]       led_q, led_d;
  logic [7:0]        sel_seg_q, sel_seg_d;
  logic [6:0]        seg_q, seg_d;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= btnD;
      btn_s_q    <= btn_meta_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             btn_deb_q, btn_deb_d;

  // Counts consecutive cycles in which the synchronized button disagrees
  // with the accepted state; any agreement restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if (btn_s_q != btn_deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CNT - 1)) begin
        btn_deb_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      btn_deb_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      btn_deb_q <= btn_deb_d;
    end
  end

  assign en = btn_deb_q;
`else
  assign en = btn_s_q;
`endif

  // Scan counter and digit selector; free-running regardless of enable.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      digit_d    = (digit_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end
  end

  // Output next-state: blank unless enabled; uses the digit currently
  // selected, so a toggle becomes visible one cycle after the wrap.
  always_comb begin
    led_d     = '0;
    sel_seg_d = '1;
    seg_d     = '1;
    if (en) begin
      led_d = 16'h0001 << sw_s_q;
      if (digit_q == DIG_UNITS) begin
        sel_seg_d = 8'b11111110;
        seg_d     = seg_pattern((sw_s_q >= 4'd10) ? (sw_s_q - 4'd10) : sw_s_q);
      end else begin
        sel_seg_d = 8'b11111101;
        if (sw_s_q >= 4'd10) begin
          seg_d = seg_pattern(4'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= DIG_UNITS;
      led_q      <= '0;
      sel_seg_q  <= '1;
      seg_q      <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      led_q      <= led_d;
      sel_seg_q  <= sel_seg_d;
      seg_q      <= seg_d;
    end
  end

  assign led     = led_q;
  assign sel_seg = sel_seg_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Testbench for onehot_decoder_scan. Stimulus is issued on the falling
// edge; the expected registered outputs for the following rising edge are
// derived from the input history and pushed to a queue, and a monitor pops
// and compares them shortly after each rising edge.
module tb_onehot_decoder_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB_CNT  = 8;
  localparam int unsigned HIST     = 8192;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        btnD = 1'b0;
  logic [3:0]  sw   = 4'd0;
  logic [15:0] led;
  logic [7:0]  sel_seg;
  logic [6:0]  seg;

  onehot_decoder_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btnD    (btnD),
    .sw      (sw),
    .led     (led),
    .sel_seg (sel_seg),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] led;
    logic [7:0]  sel;
    logic [6:0]  seg;
    int unsigned e;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0]  sw_h  [0:HIST-1];
  logic        btn_h [0:HIST-1];
  int unsigned e_cnt   = 0;   // rising edges since reset release
  logic        deb_d   = 1'b0;
  int unsigned deb_run = 0;

  function automatic logic [6:0] glyph(input int unsigned d);
    logic [6:0] t [0:9];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100;
    t[3] = 7'b0110000; t[4] = 7'b0011001; t[5] = 7'b0010010;
    t[6] = 7'b0000010; t[7] = 7'b1111000; t[8] = 7'b0000000;
    t[9] = 7'b0010000;
    return t[d];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Drive one cycle of input and predict the outputs after the next edge.
  task automatic step(input logic [3:0] s, input logic b);
    exp_t        x;
    int unsigned v;
    logic        btns;
    logic        en;
    int unsigned dig;
    @(negedge clk);
    sw   = s;
    btnD = b;
    e_cnt++;
    sw_h[e_cnt]  = s;
    btn_h[e_cnt] = b;
    // Values seen by the output stage: inputs sampled two edges earlier.
    v    = (e_cnt >= 3) ? int'(sw_h[e_cnt-2]) : 0;
    btns = (e_cnt >= 3) ? btn_h[e_cnt-2] : 1'b0;
`ifdef BTN_DEBOUNCE_EN
    en = deb_d;
    if (btns != deb_d) begin
      deb_run++;
      if (deb_run == DEB_CNT) begin
        deb_d   = btns;
        deb_run = 0;
      end
    end else begin
      deb_run = 0;
    end
`else
    en = btns;
`endif
    dig   = ((e_cnt - 1) / SCAN_DIV) % 2;
    x.e   = e_cnt;
    x.led = '0;
    x.sel = 8'hFF;
    x.seg = 7'h7F;
    if (en) begin
      x.led[v] = 1'b1;
      if (dig == 0) begin
        x.sel = 8'hFE;
        x.seg = glyph(v % 10);
      end else begin
        x.sel = 8'hFD;
        if (v / 10 == 1) x.seg = glyph(1);
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_sel_seg", 32'(sel_seg), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    repeat (2) @(posedge clk);
    #3;
    rst     = 1'b0;
    e_cnt   = 0;
    deb_d   = 1'b0;
    deb_run = 0;
  endtask

  always begin : monitor
    exp_t x;
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check($sformatf("led@e%0d", x.e), 32'(led), 32'(x.led));
      check($sformatf("sel_seg@e%0d", x.e), 32'(sel_seg), 32'(x.sel));
      check($sformatf("seg@e%0d", x.e), 32'(seg), 32'(x.seg));
      if ($countones(led) > 1) begin
        check("led_onehot", 32'($countones(led)), 32'd1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin : stim
    logic [3:0]  rs;
    logic        rb;
    int unsigned hold;

    do_reset();

    // Decode sweep.
    for (int unsigned s = 0; s < 16; s++) begin
      repeat (6) step(4'(s), 1'b1);
    end

    // Scan with a two-digit value.
    repeat (16) step(4'd12, 1'b1);

    // Disable, then re-enable with the scan still running.
    repeat (9) step(4'd3, 1'b0);
    repeat (7) step(4'd3, 1'b1);

    // Single-cycle button pulse.
    repeat (4) step(4'd7, 1'b0);
    step(4'd7, 1'b1);
    repeat (6) step(4'd7, 1'b0);

    // Short pulse, then a long hold.
    repeat (5) step(4'd9, 1'b1);
    repeat (10) step(4'd9, 1'b0);
    repeat (14) step(4'd9, 1'b1);

    // Reset in the middle of an enabled run, then recovery.
    repeat (10) step(4'd5, 1'b1);
    do_reset();
    repeat (12) step(4'd5, 1'b1);

    // Randomized inputs with random hold lengths.
    repeat (80) begin
      rs   = 4'($urandom_range(0, 15));
      rb   = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 12);
      repeat (hold) begin
        if ($urandom_range(0, 5) == 0) rs = 4'($urandom_range(0, 15));
        step(rs, rb);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
